// File: rtl/gate_tt_pkg.sv
// Shared types and constants for the gate truth-table sweeper.
package gate_tt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int VEC_COUNT = 4;

    // Truth tables indexed by {a,b}
    localparam logic [3:0] NAND_TT = 4'b0111;
    localparam logic [3:0] AND_TT  = 4'b1000;
    localparam logic [3:0] OR_TT   = 4'b1110;
    localparam logic [3:0] NOR_TT  = 4'b0001;
    localparam logic [3:0] XOR_TT  = 4'b0110;
    localparam logic [3:0] XNOR_TT = 4'b1001;

endpackage

// File: rtl/gate_tt_sweeper_settle_timer.sv
// Loadable down-counter that stops at zero; zero flags the end of a settle window.
module settle_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/gate_tt_sweeper.sv
// Drives a 2-input gate through all four input vectors and scores its truth table.
module gate_tt_sweeper
    import gate_tt_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] EXP_TT        = NAND_TT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] obs_tt,
    output logic [3:0] mismatch,
    output logic [2:0] err_cnt
);

    localparam int               CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0]       LAST_IDX = 2'(VEC_COUNT - 1);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
            $error("gate_tt_sweeper: SETTLE_CYCLES must be in 1..255");
        end
    endgenerate

    state_t     state;
    logic [1:0] idx;
    logic       timer_load;
    logic       timer_en;
    logic       timer_zero;
    logic       sample_hit;
    logic       mis_bit;

    assign sample_hit = (state == APPLY) && timer_zero;
    assign mis_bit    = y_in ^ EXP_TT[idx];
    assign timer_en   = (state == APPLY);
    assign timer_load = ((state == IDLE) && start) || (sample_hit && (idx != LAST_IDX));

    settle_timer #(
        .WIDTH(CNT_W)
    ) u_settle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .load_val(RELOAD),
        .en      (timer_en),
        .zero    (timer_zero)
    );

    // pass is resolved on the final sample edge so it is already valid alongside done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= 2'd0;
            a_out    <= 1'b0;
            b_out    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            obs_tt   <= 4'b0;
            mismatch <= 4'b0;
            err_cnt  <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= APPLY;
                        busy     <= 1'b1;
                        idx      <= 2'd0;
                        a_out    <= 1'b0;
                        b_out    <= 1'b0;
                        pass     <= 1'b0;
                        obs_tt   <= 4'b0;
                        mismatch <= 4'b0;
                        err_cnt  <= 3'd0;
                    end
                end
                APPLY: begin
                    if (timer_zero) begin
                        obs_tt[idx]   <= y_in;
                        mismatch[idx] <= mis_bit;
                        err_cnt       <= err_cnt + {2'b00, mis_bit};
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            idx   <= 2'd0;
                            a_out <= 1'b0;
                            b_out <= 1'b0;
                            pass  <= (err_cnt == 3'd0) && !mis_bit;
                        end else begin
                            idx            <= idx + 2'd1;
                            {a_out, b_out} <= idx + 2'd1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_tt_sweeper.sv
// Directed bench: two sweepers (settle 2 and settle 1) driving modelled gates.
module tb_gate_tt_sweeper;
    import gate_tt_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    int         tests_run = 0;
    int         tests_failed = 0;

    logic       start2, y2, a2, b2, busy2, done2, pass2;
    logic [3:0] obs2, mis2, tt2;
    logic [2:0] err2;

    logic       start1, y1, a1, b1, busy1, done1, pass1;
    logic [3:0] obs1, mis1, tt1;
    logic [2:0] err1;

    int         done_count;

    always #5 clk = ~clk;

    // Gate models: output is the selected truth table indexed by the driven inputs
    always_comb begin
        y2 = tt2[{a2, b2}];
        y1 = tt1[{a1, b1}];
    end

    gate_tt_sweeper #(.SETTLE_CYCLES(2), .EXP_TT(NAND_TT)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .y_in(y2),
        .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2),
        .obs_tt(obs2), .mismatch(mis2), .err_cnt(err2)
    );

    gate_tt_sweeper #(.SETTLE_CYCLES(1), .EXP_TT(NAND_TT)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .y_in(y1),
        .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
        .obs_tt(obs1), .mismatch(mis1), .err_cnt(err1)
    );

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, " dut2 ab"},   {6'b0, a2, b2}, 8'h00);
        check_output({tag, " dut2 flags"}, {5'b0, busy2, done2, pass2}, 8'h00);
        check_output({tag, " dut2 obs"},  {4'b0, obs2}, 8'h00);
        check_output({tag, " dut2 mis"},  {4'b0, mis2}, 8'h00);
        check_output({tag, " dut2 err"},  {5'b0, err2}, 8'h00);
        check_output({tag, " dut1 flags"}, {5'b0, busy1, done1, pass1}, 8'h00);
        check_output({tag, " dut1 obs"},  {4'b0, obs1}, 8'h00);
        check_output({tag, " dut1 err"},  {5'b0, err1}, 8'h00);
    endtask

    initial begin
        rst_n  = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        tt2    = NAND_TT;
        tt1    = 4'b1111;
        #3;
        check_reset_state("power-on reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // NAND sweep, settle 2
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_output($sformatf("nand ab k=%0d", k), {6'b0, a2, b2}, 8'(k >> 1));
            check_output($sformatf("nand busy/done k=%0d", k), {6'b0, busy2, done2}, 8'h02);
            tick();
        end
        check_output("nand done pulse", {6'b0, busy2, done2}, 8'h01);
        check_output("nand ab idle", {6'b0, a2, b2}, 8'h00);
        check_output("nand obs", {4'b0, obs2}, 8'h07);
        check_output("nand mis", {4'b0, mis2}, 8'h00);
        check_output("nand err", {5'b0, err2}, 8'h00);
        check_output("nand pass", {7'b0, pass2}, 8'h01);
        tick();
        check_output("nand done drop", {6'b0, busy2, done2}, 8'h00);
        check_output("nand pass hold", {7'b0, pass2}, 8'h01);
        check_output("nand obs hold", {4'b0, obs2}, 8'h07);

        // AND gate against NAND expectation
        tt2    = AND_TT;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check_output("and clear obs", {4'b0, obs2}, 8'h00);
        check_output("and clear pass", {7'b0, pass2}, 8'h00);
        for (int k = 0; k < 7; k++) tick();
        check_output("and still busy", {6'b0, busy2, done2}, 8'h02);
        tick();
        check_output("and done pulse", {6'b0, busy2, done2}, 8'h01);
        check_output("and obs", {4'b0, obs2}, 8'h08);
        check_output("and mis", {4'b0, mis2}, 8'h0f);
        check_output("and err", {5'b0, err2}, 8'h04);
        check_output("and pass", {7'b0, pass2}, 8'h00);
        tick();

        // y stuck at 1, settle 1
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_output($sformatf("stuck ab k=%0d", k), {6'b0, a1, b1}, 8'(k));
            check_output($sformatf("stuck busy k=%0d", k), {6'b0, busy1, done1}, 8'h02);
            tick();
        end
        check_output("stuck done pulse", {6'b0, busy1, done1}, 8'h01);
        check_output("stuck obs", {4'b0, obs1}, 8'h0f);
        check_output("stuck mis", {4'b0, mis1}, 8'h08);
        check_output("stuck err", {5'b0, err1}, 8'h01);
        check_output("stuck pass", {7'b0, pass1}, 8'h00);
        tick();
        check_output("stuck done drop", {7'b0, done1}, 8'h00);

        // Start pulsed mid-sweep is ignored
        tt2        = NAND_TT;
        done_count = 0;
        start2     = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) start2 = 1'b1;
            if (k == 4) start2 = 1'b0;
            if (done2) done_count++;
            tick();
        end
        check_output("midpulse done at 8", {6'b0, busy2, done2}, 8'h01);
        check_output("midpulse no early done", 8'(done_count), 8'h00);
        tick();
        tick();
        check_output("midpulse no restart", {6'b0, busy2, done2}, 8'h00);

        // Start held high: back-to-back sweeps, AND then NAND
        tt2    = AND_TT;
        start2 = 1'b1;
        tick();
        done_count = 0;
        for (int k = 0; k < 8; k++) begin
            if (done2) done_count++;
            tick();
        end
        check_output("held first done", {6'b0, busy2, done2}, 8'h01);
        check_output("held first err", {5'b0, err2}, 8'h04);
        tt2 = NAND_TT;
        tick();
        check_output("held gap idle", {6'b0, busy2, done2}, 8'h00);
        tick();
        check_output("held relaunch busy", {6'b0, busy2, done2}, 8'h02);
        check_output("held relaunch clear err", {5'b0, err2}, 8'h00);
        check_output("held relaunch clear mis", {4'b0, mis2}, 8'h00);
        start2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (done2) done_count++;
            tick();
        end
        check_output("held second done", {6'b0, busy2, done2}, 8'h01);
        check_output("held second pass", {7'b0, pass2}, 8'h01);
        check_output("held done count", 8'(done_count), 8'h00);
        tick();

        // Reset asserted mid-cycle during vector 10
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check_output("abort at vector 10", {6'b0, a2, b2}, 8'h02);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("mid-sweep reset");
        done_count = 0;
        for (int k = 0; k < 6; k++) begin
            if (done2) done_count++;
            tick();
        end
        check_output("abort no done", 8'(done_count), 8'h00);
        rst_n = 1'b1;
        tick();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check_output("post-reset done", {6'b0, busy2, done2}, 8'h01);
        check_output("post-reset obs", {4'b0, obs2}, 8'h07);
        check_output("post-reset pass", {7'b0, pass2}, 8'h01);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/gate_tt_sweeper.md
Name: gate_tt_sweeper

Overview:
Sequential stimulus-and-check stage wrapped around a 2-input gate such as nand_gate. On a start request it drives the gate inputs (a, b) through all four vectors 00, 01, 10, 11. Each vector is held for a programmable settle time before the gate output y is sampled. The captured truth table is compared against an expected table, and the block reports a per-vector mismatch mask, an error count and pass/fail. It is the on-chip replacement for the hand-written truth-table bench: the upstream feeder of the gate and the downstream consumer of its output.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before y is sampled; legal 1..255; 0 is a compile-time error
EXP_TT, 4'b0111, expected truth table; bit index = {a,b}; default = NAND

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  run request; sampled only in IDLE
y_in  input  1  gate output under test
a_out  output  1  gate input a, registered
b_out  output  1  gate input b, registered
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse when results become valid
pass  output  1  1 when the last completed sweep had zero errors
obs_tt  output  4  captured y per vector, bit {a,b}
mismatch  output  4  obs_tt XOR EXP_TT, per vector
err_cnt  output  3  number of mismatching vectors, 0..4

Behaviour:
- Reset (rst_n low, async): state IDLE; a_out, b_out, busy, done, pass = 0; obs_tt, mismatch = 4'b0; err_cnt = 0; idx = 0; settle counter = 0.
- FSM has three states: IDLE, APPLY, DONE.
- IDLE:
  - start=1 at edge E0 -> APPLY, busy=1, idx=0, {a_out,b_out}=00, cnt=SETTLE_CYCLES-1.
  - On the same edge, clear obs_tt, mismatch, err_cnt and pass to 0.
- APPLY: {a_out,b_out} = idx at all times. On each edge:
  - cnt!=0 -> cnt decrements.
  - cnt==0 -> sample y_in: obs_tt[idx] <= y_in; mismatch[idx] <= y_in ^ EXP_TT[idx]; err_cnt increments on mismatch.
  - If the sample was taken with idx<3: idx increments, cnt reloads to SETTLE_CYCLES-1.
  - If the sample was taken with idx==3: -> DONE, busy=0, {a_out,b_out}=00.
- Timing: vector k is sampled at edge E0+(k+1)*SETTLE_CYCLES. The last sample is at E0+4*SETTLE_CYCLES, and done is high for the cycle following that edge.
- DONE: done=1 for exactly one cycle. pass = (final err_cnt==0), using the value including the vector-3 result. Then -> IDLE.
- obs_tt, mismatch, err_cnt and pass hold their values after DONE until the next accepted start.
- start while in APPLY or DONE is ignored; no restart, no queueing. A start held high continuously launches a new sweep on the first IDLE edge after DONE.
- Reset mid-sweep aborts immediately: no done pulse, all outputs at reset values.
- err_cnt is 3 bits and cannot overflow, since its maximum value is 4.
- Busy duration is exactly 4*SETTLE_CYCLES cycles. start-to-done latency is 4*SETTLE_CYCLES+1 edges.

Decomposition:
- Package gate_tt_pkg holds:
  - state enum {IDLE, APPLY, DONE};
  - constant VEC_COUNT=4;
  - truth-table constants NAND_TT=4'b0111, AND_TT=4'b1000, OR_TT=4'b1110, NOR_TT=4'b0001, XOR_TT=4'b0110, XNOR_TT=4'b1001.
- One natural sub-module: settle_timer, a loadable down-counter with zero flag, width $clog2(SETTLE_CYCLES+1).
- The FSM, vector index and scoreboard stay in the top module.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle -> all outputs 0 asynchronously, before the next clk edge.
2. nand_gate attached, SETTLE_CYCLES=2, start pulse at E0 -> a/b = 00,01,10,11, each held 2 cycles; done high after E0+8; obs_tt=0111, mismatch=0000, err_cnt=0, pass=1; busy high exactly 8 cycles.
3. AND gate substituted, default EXP_TT -> obs_tt=1000, mismatch=1111, err_cnt=4, pass=0.
4. y_in stuck at 1, SETTLE_CYCLES=1 -> obs_tt=1111, mismatch=1000, err_cnt=1, pass=0; done after E0+4.
5. start pulsed during APPLY, and start held high continuously -> mid-sweep pulses ignored. Back-to-back sweeps each clear the results at start and each produce exactly one done pulse.
6. rst_n low during vector 10 -> outputs zero immediately, no done. A subsequent start completes a clean sweep with pass=1 against nand_gate.
